// File: rtl/ship_tilt_ctrl.sv
// Tilt-driven spaceship x position: dead-zone, sub-pixel velocity,
// screen clamping and a stale-sample freeze, updated once per frame.
module ship_tilt_ctrl #(
    parameter int H_RES        = 640,
    parameter int SCREEN_CORDW = 16,
    parameter int SPRITE_W_PX  = 51,
    parameter int START_X      = 295,
    parameter int SHIP_Y       = 300,
    parameter int DEAD_ZONE    = 16,
    parameter int SHIFT        = 2,
    parameter int MAX_SPEED    = 4,
    parameter int FRAC_BITS    = 4,
    parameter int STALE_FRAMES = 8,
    parameter bit INVERT       = 1'b0
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    accel_valid,
    input  logic signed [15:0]      accel_x,
    input  logic                    en,
    input  logic                    recenter,
    output logic [SCREEN_CORDW-1:0] sprite_x,
    output logic [SCREEN_CORDW-1:0] sprite_y,
    output logic                    at_left,
    output logic                    at_right,
    output logic                    stale
);

    localparam int PW    = SCREEN_CORDW + FRAC_BITS;
    localparam int X_MAX = H_RES - SPRITE_W_PX;
    localparam int SW    = $clog2(STALE_FRAMES + 1);

    localparam logic [PW-1:0] POS_MAX   = PW'(X_MAX * (1 << FRAC_BITS));
    localparam logic [PW-1:0] POS_START = PW'(START_X * (1 << FRAC_BITS));
    localparam logic [15:0]   VMAX      = 16'(MAX_SPEED * (1 << FRAC_BITS));
    localparam logic [15:0]   DZ        = 16'(DEAD_ZONE);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

    logic signed [15:0] tilt_q;
    logic [PW-1:0]      pos_q, pos_d;
    logic               left_q, left_d;
    logic               right_q, right_d;
    logic [SW-1:0]      cnt_q, cnt_d;

    logic signed [15:0]   t;
    logic [15:0]          m;
    logic [15:0]          excess;
    logic [15:0]          vmag;
    logic signed [PW+1:0] v;
    logic signed [PW+1:0] nxt;

    assign stale = (cnt_q == STALE_MAX);

    // -32768 has no positive twin, so both negation and |t| saturate.
    always_comb begin
        t = tilt_q;
        if (INVERT) begin
            t = (tilt_q == 16'sh8000) ? 16'sh7fff : -tilt_q;
        end
        if (t == 16'sh8000) begin
            m = 16'h7fff;
        end else if (t[15]) begin
            m = 16'(-t);
        end else begin
            m = 16'(t);
        end
        excess = '0;
        vmag   = '0;
        if (m > DZ) begin
            excess = (m - DZ) >> SHIFT;
            vmag   = (excess > VMAX) ? VMAX : excess;
        end
        v = signed'((PW + 2)'(vmag));
        if (t[15]) begin
            v = -v;
        end
        nxt = signed'({2'b00, pos_q}) + v;
    end

    always_comb begin
        pos_d   = pos_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        if (accel_valid) begin
            cnt_d = '0;
        end else if (frame && !stale) begin
            cnt_d = cnt_q + SW'(1);
        end
        if (recenter) begin
            pos_d   = POS_START;
            left_d  = 1'b0;
            right_d = 1'b0;
        end else if (frame && en && !stale) begin
            left_d  = 1'b0;
            right_d = 1'b0;
            if (nxt < 0) begin
                pos_d  = '0;
                left_d = 1'b1;
            end else if (nxt > signed'({2'b00, POS_MAX})) begin
                pos_d   = POS_MAX;
                right_d = 1'b1;
            end else begin
                pos_d = nxt[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            tilt_q  <= '0;
            pos_q   <= POS_START;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accel_valid) begin
                tilt_q <= accel_x;
            end
            pos_q   <= pos_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sprite_x = pos_q[PW-1:FRAC_BITS];
    assign sprite_y = SCREEN_CORDW'(SHIP_Y);
    assign at_left  = left_q;
    assign at_right = right_q;

endmodule

// File: tb/tb_ship_tilt_ctrl.sv
// Directed bench for ship_tilt_ctrl: a default instance plus an
// INVERT=1 instance sharing the same stimulus.
module tb_ship_tilt_ctrl;

    logic               clk_pix = 1'b0;
    logic               rst = 1'b1;
    logic               frame = 1'b0;
    logic               accel_valid = 1'b0;
    logic signed [15:0] accel_x = '0;
    logic               en = 1'b1;
    logic               recenter = 1'b0;

    logic [15:0] sprite_x, sprite_y, isprite_x, isprite_y;
    logic        at_left, at_right, stale;
    logic        iat_left, iat_right, istale;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_pix = ~clk_pix;

    ship_tilt_ctrl dut (
        .clk_pix(clk_pix), .rst(rst), .frame(frame),
        .accel_valid(accel_valid), .accel_x(accel_x), .en(en),
        .recenter(recenter), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .at_left(at_left), .at_right(at_right), .stale(stale)
    );

    ship_tilt_ctrl #(.INVERT(1'b1)) dut_inv (
        .clk_pix(clk_pix), .rst(rst), .frame(frame),
        .accel_valid(accel_valid), .accel_x(accel_x), .en(en),
        .recenter(recenter), .sprite_x(isprite_x), .sprite_y(isprite_y),
        .at_left(iat_left), .at_right(iat_right), .stale(istale)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic sample(input logic signed [15:0] x);
        accel_x = x;
        accel_valid = 1'b1;
        tick();
        accel_valid = 1'b0;
    endtask

    task automatic frm();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
    endtask

    task automatic frames(input int n, input logic signed [15:0] x,
                          input bit fresh);
        for (int i = 0; i < n; i++) begin
            if (fresh) sample(x);
            frm();
        end
    endtask

    initial begin
        do_reset();
        chk("rst_x", sprite_x, 295);
        chk("rst_y", sprite_y, 300);
        chk("rst_left", at_left, 0);
        chk("rst_right", at_right, 0);
        chk("rst_stale", stale, 0);

        frames(10, 16'sd80, 1'b1);
        chk("p80_x", sprite_x, 305);
        chk("p80_flags", {at_left, at_right}, 0);

        do_reset();
        frames(5, 16'sd10, 1'b1);
        chk("dz10_x", sprite_x, 295);
        frames(3, 16'sd16, 1'b1);
        chk("dz16_x", sprite_x, 295);

        do_reset();
        frames(73, 16'sd10000, 1'b1);
        chk("fast73_x", sprite_x, 587);
        chk("fast73_right", at_right, 0);
        frames(1, 16'sd10000, 1'b1);
        chk("fast74_x", sprite_x, 589);
        chk("fast74_right", at_right, 1);
        frames(3, 16'sd10000, 1'b1);
        chk("fast_hold_x", sprite_x, 589);
        chk("fast_hold_right", at_right, 1);

        do_reset();
        frames(1, -16'sd20, 1'b1);
        chk("neg20_1_x", sprite_x, 294);
        chk("neg20_1_pos", dut.pos_q, 4719);
        frames(15, -16'sd20, 1'b1);
        chk("neg20_16_x", sprite_x, 294);
        chk("neg20_16_pos", dut.pos_q, 4704);

        do_reset();
        sample(16'sd80);
        frames(7, 16'sd0, 1'b0);
        chk("stale7_x", sprite_x, 302);
        chk("stale7_flag", stale, 0);
        frames(1, 16'sd0, 1'b0);
        chk("stale8_x", sprite_x, 303);
        chk("stale8_flag", stale, 1);
        frames(2, 16'sd0, 1'b0);
        chk("stale10_x", sprite_x, 303);
        sample(16'sd80);
        chk("stale_clr", stale, 0);
        frm();
        chk("stale_move_x", sprite_x, 304);

        en = 1'b0;
        frames(3, 16'sd80, 1'b1);
        chk("en0_x", sprite_x, 304);
        en = 1'b1;

        accel_x = -16'sd10000;
        accel_valid = 1'b1;
        frame = 1'b1;
        tick();
        accel_valid = 1'b0;
        frame = 1'b0;
        chk("samecyc_x", sprite_x, 305);
        tick();
        frm();
        chk("samecyc_next_x", sprite_x, 301);

        do_reset();
        frames(26, 16'sd10000, 1'b1);
        frames(1, 16'sd80, 1'b1);
        chk("pre_rc_x", sprite_x, 400);
        recenter = 1'b1;
        frame = 1'b1;
        tick();
        recenter = 1'b0;
        frame = 1'b0;
        chk("rc_x", sprite_x, 295);
        chk("rc_flags", {at_left, at_right}, 0);

        frames(73, -16'sd10000, 1'b1);
        chk("left73_x", sprite_x, 3);
        frames(1, -16'sd10000, 1'b1);
        chk("left74_x", sprite_x, 0);
        chk("left74_left", at_left, 1);

        frame = 1'b1;
        tick();
        rst = 1'b1;
        frame = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_x", sprite_x, 295);
        chk("midrst_left", at_left, 0);

        do_reset();
        frames(1, -16'sh8000, 1'b1);
        chk("inv_x", isprite_x, 299);
        chk("noninv_min_x", sprite_x, 291);
        frames(1, -16'sh8000, 1'b1);
        chk("inv_x2", isprite_x, 303);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
